// File: rtl/solar_pkg.sv
// Constants and types shared across the solar tracker: the servo pulse-width
// limits used by the PWM generator, the default sample width, and the tracker FSM state type.
package solar_pkg;

  localparam int unsigned PW_MIN     = 500;   // 0 deg
  localparam int unsigned PW_MAX_LIM = 2500;  // 180 deg
  localparam int unsigned DATA_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    TRACK = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/irr_peak_tracker_if.sv
// Sample handshake between the ADC front end (master) and the peak tracker (slave).
interface irr_peak_tracker_if #(
  parameter int unsigned DATA_W = 12
) ();
  logic [DATA_W-1:0] SAMPLE;
  logic              SAMPLE_VLD;
  logic              SAMPLE_RDY;

  modport master (output SAMPLE, output SAMPLE_VLD, input SAMPLE_RDY);
  modport slave  (input SAMPLE, input SAMPLE_VLD, output SAMPLE_RDY);
endinterface

// File: rtl/irr_peak_tracker_sample_avg4.sv
// Groups accepted samples in fours and presents their mean on the fourth one.
// avg/avg_vld are combinational, so the mean can be compared in the same cycle as the 4th sample.
module sample_avg4 #(
  parameter int unsigned DATA_W = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] avg,
  output logic              avg_vld
);

  logic [DATA_W+1:0] acc_q;
  logic [DATA_W+1:0] sum;
  logic [1:0]        cnt_q;

  // Four DATA_W-bit values always fit in DATA_W+2 bits, so the sum cannot wrap.
  assign sum     = acc_q + (DATA_W+2)'(in_data);
  assign avg     = DATA_W'(sum >> 2);
  assign avg_vld = in_vld && (cnt_q == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (in_vld) begin
      acc_q <= (cnt_q == 2'd3) ? '0 : sum;
      cnt_q <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/irr_peak_tracker.sv
// Tracks peak irradiance over a calibration sweep and latches the servo pulse width where it occurred.
// Define IRR_PEAK_AVG_EN to compare 4-sample averages instead of individual samples.
module irr_peak_tracker #(
  parameter int unsigned DATA_W     = solar_pkg::DATA_W_DEF,
  parameter int unsigned PW_W       = 32,
  parameter int unsigned PW_MIN     = solar_pkg::PW_MIN,
  parameter int unsigned PW_MAX_LIM = solar_pkg::PW_MAX_LIM
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ES,
  input  logic [PW_W-1:0]     PW,
  irr_peak_tracker_if.slave   smp,
  output logic [PW_W-1:0]     PW_MAX,
  output logic [DATA_W-1:0]   IRR_MAX,
  output logic                BUSY,
  output logic                DONE
);

  import solar_pkg::*;

  state_t state_q;
  state_t state_d;
  logic   es_q;
  logic   es_rise;
  logic   es_fall;
  logic   hs;
  logic   pw_ok;
  logic   acc_vld;
  logic   cmp_vld;
  logic [DATA_W-1:0] cmp_val;

  assign es_rise = ES && !es_q;
  assign es_fall = !ES && es_q;
  assign hs      = smp.SAMPLE_VLD && smp.SAMPLE_RDY;
  assign pw_ok   = (PW >= PW_W'(PW_MIN)) && (PW <= PW_W'(PW_MAX_LIM));
  // Out-of-range samples are still handshaken, just never compared.
  assign acc_vld = hs && pw_ok;

`ifdef IRR_PEAK_AVG_EN
  sample_avg4 #(
    .DATA_W (DATA_W)
  ) u_avg (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (state_q == ARM),
    .in_vld  (acc_vld),
    .in_data (smp.SAMPLE),
    .avg     (cmp_val),
    .avg_vld (cmp_vld)
  );
`else
  assign cmp_val = smp.SAMPLE;
  assign cmp_vld = acc_vld;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      es_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      es_q    <= ES;
    end
  end

  // NOTE: a default assignment first in every always_comb keeps all paths assigned, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (es_rise) state_d = ARM;
      ARM:     state_d = TRACK;
      TRACK:   if (es_fall) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    smp.SAMPLE_RDY = 1'b0;
    BUSY           = 1'b0;
    DONE           = 1'b0;
    case (state_q)
      ARM:   BUSY = 1'b1;
      TRACK: begin
        smp.SAMPLE_RDY = 1'b1;
        BUSY           = 1'b1;
      end
      FIN:   DONE = 1'b1;
      default: ;
    endcase
  end

  // Strict greater-than keeps the earliest position on ties.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PW_MAX  <= PW_W'(PW_MIN);
      IRR_MAX <= '0;
    end else if (state_q == ARM) begin
      PW_MAX  <= PW_W'(PW_MIN);
      IRR_MAX <= '0;
    end else if (state_q == TRACK && cmp_vld && cmp_val > IRR_MAX) begin
      PW_MAX  <= PW;
      IRR_MAX <= cmp_val;
    end
  end

endmodule

// File: tb/tb_irr_peak_tracker.sv
// Directed bench for irr_peak_tracker: each sweep pushes its expected result into a
// scoreboard, and a monitor pops and compares whenever DONE is presented.
module tb_irr_peak_tracker;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ES;
  logic [31:0] PW;
  logic [31:0] PW_MAX;
  logic [11:0] IRR_MAX;
  logic        BUSY;
  logic        DONE;

  irr_peak_tracker_if #(.DATA_W(12)) smp ();

  irr_peak_tracker dut (
    .CLK     (CLK),
    .RST     (RST),
    .ES      (ES),
    .PW      (PW),
    .smp     (smp),
    .PW_MAX  (PW_MAX),
    .IRR_MAX (IRR_MAX),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

`ifdef IRR_PEAK_AVG_EN
  localparam logic [31:0] EXP_A_PW = 500,  EXP_A_IRR = 0;
  localparam logic [31:0] EXP_T_PW = 500,  EXP_T_IRR = 0;
  localparam logic [31:0] EXP_O_PW = 500,  EXP_O_IRR = 0;
  localparam logic [31:0] EXP_V_PW = 830,  EXP_V_IRR = 250;
`else
  localparam logic [31:0] EXP_A_PW = 510,  EXP_A_IRR = 300;
  localparam logic [31:0] EXP_T_PW = 600,  EXP_T_IRR = 400;
  localparam logic [31:0] EXP_O_PW = 1000, EXP_O_IRR = 50;
  localparam logic [31:0] EXP_V_PW = 900,  EXP_V_IRR = 1000;
`endif

  typedef struct {
    logic [31:0] pw;
    logic [31:0] irr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest pending sweep result.
  always @(negedge CLK) begin
    if (!RST && DONE) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_done: got DONE=1, expected no pending result");
      end else begin
        mon_e = sb.pop_front();
        check("sb_pw_max", PW_MAX, mon_e.pw);
        check("sb_irr_max", 32'(IRR_MAX), mon_e.irr);
      end
    end
  end

  task automatic start_sweep();
    ES = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("arm_busy", 32'(BUSY), 1);
    check("arm_rdy", 32'(smp.SAMPLE_RDY), 0);
    @(negedge CLK);
    check("track_rdy", 32'(smp.SAMPLE_RDY), 1);
    check("track_clr_pw", PW_MAX, 500);
    check("track_clr_irr", 32'(IRR_MAX), 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] pw, input logic [11:0] s);
    bit got = 1'b0;
    PW             = pw;
    smp.SAMPLE     = s;
    smp.SAMPLE_VLD = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (smp.SAMPLE_RDY) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got SAMPLE_RDY=0 for 20 cycles, expected 1");
    end
    @(posedge CLK);
    #1;
    smp.SAMPLE_VLD = 1'b0;
  endtask

  task automatic end_sweep(input logic [31:0] epw, input logic [31:0] eirr);
    sb.push_back('{epw, eirr});
    ES = 1'b0;
    @(negedge CLK);
    check("fall_done_early", 32'(DONE), 0);
    check("fall_busy", 32'(BUSY), 1);
    @(negedge CLK);
    check("fin_done", 32'(DONE), 1);
    check("fin_busy", 32'(BUSY), 0);
    check("fin_rdy", 32'(smp.SAMPLE_RDY), 0);
    @(negedge CLK);
    check("done_one_cycle", 32'(DONE), 0);
    @(posedge CLK);
    #1;
  endtask

  // Last sample presented in the same cycle ES falls: still accepted and compared.
  task automatic finish_with(input logic [31:0] pw, input logic [11:0] s,
                             input logic [31:0] epw, input logic [31:0] eirr);
    sb.push_back('{epw, eirr});
    PW             = pw;
    smp.SAMPLE     = s;
    smp.SAMPLE_VLD = 1'b1;
    ES             = 1'b0;
    @(posedge CLK);
    #1;
    smp.SAMPLE_VLD = 1'b0;
    @(negedge CLK);
    check("fall_hs_done", 32'(DONE), 1);
    @(negedge CLK);
    check("fall_hs_done_end", 32'(DONE), 0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST            = 1'b1;
    ES             = 1'b0;
    PW             = 500;
    smp.SAMPLE     = '0;
    smp.SAMPLE_VLD = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_pw_max", PW_MAX, 500);
    check("rst_irr_max", 32'(IRR_MAX), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_rdy", 32'(smp.SAMPLE_RDY), 0);
    check("rst_done", 32'(DONE), 0);
    @(posedge CLK);
    #1;

    // Basic peak search.
    start_sweep();
    send(500, 100);
    send(510, 300);
    send(520, 250);
    end_sweep(EXP_A_PW, EXP_A_IRR);

    // Valid held in IDLE: never accepted, result unchanged.
    PW             = 1000;
    smp.SAMPLE     = 12'd4000;
    smp.SAMPLE_VLD = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      check("idle_rdy", 32'(smp.SAMPLE_RDY), 0);
    end
    @(posedge CLK);
    #1;
    smp.SAMPLE_VLD = 1'b0;
    @(negedge CLK);
    check("idle_hold_pw", PW_MAX, EXP_A_PW);
    check("idle_hold_irr", 32'(IRR_MAX), EXP_A_IRR);
    @(posedge CLK);
    #1;

    // Tie keeps the earliest position; ARM clears the previous result.
    start_sweep();
    send(600, 400);
    send(700, 400);
    end_sweep(EXP_T_PW, EXP_T_IRR);

    // Out-of-range pulse width discarded; last sample lands on the ES fall.
    start_sweep();
    send(2600, 4000);
    finish_with(1000, 50, EXP_O_PW, EXP_O_IRR);

    // Full group of four then a partial group.
    start_sweep();
    send(800, 100);
    send(810, 200);
    send(820, 300);
    send(830, 400);
    send(900, 1000);
    send(910, 1000);
    send(920, 1000);
    end_sweep(EXP_V_PW, EXP_V_IRR);

    // Reset mid-TRACK.
    start_sweep();
    send(700, 1234);
    RST = 1'b1;
    ES  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("mid_rst_pw_max", PW_MAX, 500);
    check("mid_rst_irr_max", 32'(IRR_MAX), 0);
    check("mid_rst_busy", 32'(BUSY), 0);
    check("mid_rst_rdy", 32'(smp.SAMPLE_RDY), 0);
    repeat (4) @(negedge CLK);
    check("sb_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irr_peak_tracker.md
Name: irr_peak_tracker

Overview:
Tracks the irradiance peak during a horizontal or vertical calibration sweep and reports the servo pulse width where it occurred.
- Takes irradiance samples from the ADC front end through a valid/ready handshake.
- Compares each sample against the running maximum.
- Latches the servo pulse width (us) that was current when the maximum was seen.
- Sits directly upstream of the PWM generator: its PW_MAX output drives that block's pulseWidth_max input, which the PWM generator uses in max-position mode (MC high).

Parameters:
DATA_W, 12, width of irradiance sample (unsigned ADC code)
PW_W, 32, width of pulse-width values (us)
PW_MIN, 500, lowest valid pulse width (0 deg)
PW_MAX_LIM, 2500, highest valid pulse width (180 deg)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
ES  in  1  sweep active (HS or VS state of the sweep FSM)
PW  in  PW_W  current pulse width reported by the PWM generator
SAMPLE  in  DATA_W  irradiance sample
SAMPLE_VLD  in  1  sample valid
SAMPLE_RDY  out  1  tracker accepts sample
PW_MAX  out  PW_W  pulse width at peak irradiance
IRR_MAX  out  DATA_W  peak irradiance value
BUSY  out  1  high while a sweep is being tracked
DONE  out  1  one-cycle pulse when the sweep result is final

Behaviour:
- Reset is synchronous (RST sampled on the CLK rising edge) and applies in any state, including mid-sweep. Reset values: state IDLE, PW_MAX=PW_MIN, IRR_MAX=0, SAMPLE_RDY=0, BUSY=0, DONE=0, es_q=0.
- ES is registered into es_q. Edges are detected against es_q.
- FSM states: IDLE, ARM, TRACK, FIN.
  - IDLE: outputs hold the last result. On an ES rising edge (ES=1, es_q=0), go to ARM.
  - ARM: one cycle. Clear IRR_MAX to 0 and PW_MAX to PW_MIN. BUSY=1. Go to TRACK.
  - TRACK: SAMPLE_RDY=1 and BUSY=1.
    - A handshake occurs when SAMPLE_VLD & SAMPLE_RDY.
    - On a handshake with PW in [PW_MIN, PW_MAX_LIM] and SAMPLE > IRR_MAX, update IRR_MAX<=SAMPLE and PW_MAX<=PW on the next edge. Latency is 1 cycle.
    - The comparison is strict, so ties keep the earliest position.
    - If PW is out of range, the sample is accepted but discarded.
    - On an ES falling edge, go to FIN. A handshake in that same cycle is still accepted and compared.
  - FIN: one cycle. DONE=1, BUSY=0, SAMPLE_RDY=0. Go to IDLE.
- SAMPLE_RDY is 0 in IDLE, ARM and FIN. Upstream must hold SAMPLE/SAMPLE_VLD until ready.
- ES rising again while in FIN: the edge is seen in IDLE on the following cycle only if ES is still high and es_q is low. Otherwise it is missed. The sweep FSM guarantees at least 2 low cycles between sweeps.
- A sweep with no accepted in-range samples ends with PW_MAX=PW_MIN and IRR_MAX=0. DONE still pulses.
- Arithmetic: unsigned compare at DATA_W bits. PW_MAX is a straight copy, with no saturation needed.

Optional Feature:
Macro IRR_PEAK_AVG_EN.
- Defined:
  - Accepted in-range samples are summed in groups of 4 in a (DATA_W+2)-bit accumulator. The average (sum>>2) is compared on the 4th sample, using the PW captured at the 4th sample.
  - The accumulator clears in ARM and after each group.
  - A partial group at the ES fall is discarded.
- Undefined: every sample is compared individually, as described above.

Decomposition:
- Shared package solar_pkg holds:
  - PW_MIN=500 and PW_MAX_LIM=2500, shared with the PWM generator;
  - the FSM state typedef (2-bit: IDLE, ARM, TRACK, FIN);
  - the default DATA_W.
- Sub-module sample_avg4, instantiated only under IRR_PEAK_AVG_EN: accumulator plus 2-bit counter. Outputs avg and avg_vld.

Test Plan:
- RST high 3 cycles mid-TRACK -> next cycle state IDLE, PW_MAX=500, IRR_MAX=0, BUSY=0, SAMPLE_RDY=0.
- ES rise; samples (PW,SAMPLE) = (500,100),(510,300),(520,250); ES fall -> PW_MAX=510, IRR_MAX=300, DONE high exactly 1 cycle, 1 cycle after ES fall is registered.
- Tie: (600,400),(700,400) -> PW_MAX=600.
- Out-of-range: (2600,4000),(1000,50) -> PW_MAX=1000, IRR_MAX=50.
- SAMPLE_VLD held high in IDLE -> SAMPLE_RDY=0, no update. Second sweep -> ARM clears the previous result to 500/0 before the new samples.
- IRR_PEAK_AVG_EN: samples 100,200,300,400 @PW 800..830, then 1000,1000,1000 (partial group) -> IRR_MAX=250, PW_MAX=830.
